// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first,
// start/done handshake, sticky flag for operand digits above 9.

module bcd_digit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       bad
);
  logic [3:0] bx;
  logic [4:0] z;

  // Subtraction adds the 9's complement of b; the initial carry of 1 makes it 10's complement.
  assign bx  = sub ? (4'd9 - b) : b;
  assign z   = {1'b0, a} + {1'b0, bx} + {4'b0, ci};
  assign bad = (a > 4'd9) || (b > 4'd9);

  always_comb begin
    s  = z[3:0];
    co = 1'b0;
    if (z > 5'd9) begin
      s  = z[3:0] + 4'd6;
      co = 1'b1;
    end
  end
endmodule

module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  output logic [4*DIGITS-1:0]   S,
  output logic                  cout,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]              state;
  logic [IW-1:0]           idx;
  logic                    carry;
  logic                    lsub;
  logic [DIGITS-1:0][3:0]  la, lb, s_q;
  logic [3:0]              dsum;
  logic                    dco, dbad;

  bcd_digit u_dig (
    .a   (la[idx]),
    .b   (lb[idx]),
    .sub (lsub),
    .ci  (carry),
    .s   (dsum),
    .co  (dco),
    .bad (dbad)
  );

  assign S    = s_q;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      lsub  <= 1'b0;
      la    <= '0;
      lb    <= '0;
      s_q   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          la    <= A;
          lb    <= B;
          lsub  <= sub;
          s_q   <= '0;
          err   <= 1'b0;
          idx   <= '0;
          carry <= sub ? 1'b1 : cin;
          state <= RUN;
        end
        RUN: begin
          s_q[idx] <= dsum;
          carry    <= dco;
          if (dbad) err <= 1'b1;
          if (idx == LAST) begin
            cout  <= dco;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
